// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PIC24 program-sequencing unit.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,
    OP_BRA   = 3'd2,
    OP_LOADL = 3'd3,
    OP_GOTOH = 3'd4,
    OP_CALLH = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } pc_op_e;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_LOW_HELD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Hardware return-address LIFO; pushes when full and pops when empty are ignored.
module pc_ret_stack #(
  parameter int ADDR_W      = 24,
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic [DEPTH_W-1:0] depth,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0]  mem_r [STACK_DEPTH];
  logic [DEPTH_W-1:0] depth_r;
  logic [DEPTH_W-1:0] depth_m1_s;
  logic [PTR_W-1:0]   wr_ptr_s;
  logic [PTR_W-1:0]   top_ptr_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full       = (depth_r == DEPTH_MAX);
  assign empty      = (depth_r == {DEPTH_W{1'b0}});
  assign push_ok_s  = push & ~full;
  assign pop_ok_s   = pop & ~empty;
  assign depth_m1_s = depth_r - DEPTH_ONE;
  assign top_ptr_s  = depth_m1_s[PTR_W-1:0];
  // A simultaneous push and pop overwrites the current top in place.
  assign wr_ptr_s   = pop_ok_s ? top_ptr_s : depth_r[PTR_W-1:0];
  assign top        = mem_r[top_ptr_s];
  assign depth      = depth_r;

  // Occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_r <= {DEPTH_W{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   depth_r <= depth_r + DEPTH_ONE;
        2'b01:   depth_r <= depth_m1_s;
        default: depth_r <= depth_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_ok_s || (push && pop_ok_s)) begin
      mem_r[wr_ptr_s] <= wdata;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter with increment, relative branch, two-beat absolute GOTO/CALL and RETURN stack.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}}
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             stall_i,
  input  pc_op_e                           op_i,
  input  logic [DATA_W-1:0]                databus_i,
  input  logic [DATA_W-1:0]                offset_i,
  output logic [ADDR_W-1:0]                pc_addr_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth_o,
  output logic                             pending_o,
  output logic                             stack_ovf_o,
  output logic                             stack_unf_o
);

  localparam int EXT_W   = ADDR_W - DATA_W;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = {{(ADDR_W-2){1'b0}}, 2'b10};
  localparam logic [ADDR_W-1:0] PC_RESET = {RESET_VEC[ADDR_W-1:1], 1'b0};

  pc_state_e         state_r, state_nx_s;
  logic [ADDR_W-1:0] pc_r, pc_nx_s;
  logic [DATA_W-1:0] stage_r, stage_nx_s;
  logic              pending_r;
  logic              ovf_r, ovf_nx_s;
  logic              unf_r, unf_nx_s;
  logic              push_s, pop_s;
  logic [ADDR_W-1:0] pc_plus2_s, bra_tgt_s, abs_tgt_s, off_ext_s;
  logic [ADDR_W-1:0] stk_top_s;
  logic [DEPTH_W-1:0] stk_depth_s;
  logic              stk_full_s, stk_empty_s;

  assign pc_plus2_s = pc_r + PC_STEP;
  assign off_ext_s  = {{EXT_W{offset_i[DATA_W-1]}}, offset_i};
  assign bra_tgt_s  = pc_plus2_s + {off_ext_s[ADDR_W-2:0], 1'b0};
  assign abs_tgt_s  = {databus_i[EXT_W-1:0], stage_r};

  pc_ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .DEPTH_W     (DEPTH_W)
  ) u_stack (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pc_plus2_s),
    .top   (stk_top_s),
    .depth (stk_depth_s),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  // Sequencing state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state, next-PC and stack control.
  always_comb begin
    state_nx_s = state_r;
    pc_nx_s    = pc_r;
    stage_nx_s = stage_r;
    ovf_nx_s   = ovf_r;
    unf_nx_s   = unf_r;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    if (!stall_i) begin
      // Every op except LOADL leaves LOW_HELD and discards the staged word.
      state_nx_s = ST_IDLE;
      stage_nx_s = {DATA_W{1'b0}};
      case (op_i)
        OP_INC: pc_nx_s = pc_plus2_s;
        OP_BRA: pc_nx_s = bra_tgt_s;
        OP_LOADL: begin
          stage_nx_s = {databus_i[DATA_W-1:1], 1'b0};
          state_nx_s = ST_LOW_HELD;
        end
        OP_GOTOH: begin
          if (state_r == ST_LOW_HELD) begin
            pc_nx_s = abs_tgt_s;
          end else begin
            pc_nx_s = pc_r;
          end
        end
        OP_CALLH: begin
          if (state_r == ST_LOW_HELD) begin
            pc_nx_s  = abs_tgt_s;
            push_s   = 1'b1;
            ovf_nx_s = ovf_r | stk_full_s;
          end else begin
            pc_nx_s = pc_r;
          end
        end
        OP_RET: begin
          if (stk_empty_s) begin
            pc_nx_s  = PC_RESET;
            unf_nx_s = 1'b1;
          end else begin
            pc_nx_s = stk_top_s;
            pop_s   = 1'b1;
          end
        end
        default: pc_nx_s = pc_r;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // PC, staged low word, pending indicator and sticky stack flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r      <= PC_RESET;
      stage_r   <= {DATA_W{1'b0}};
      pending_r <= 1'b0;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else begin
      pc_r      <= {pc_nx_s[ADDR_W-1:1], 1'b0};
      stage_r   <= stage_nx_s;
      pending_r <= (state_nx_s == ST_LOW_HELD);
      ovf_r     <= ovf_nx_s;
      unf_r     <= unf_nx_s;
    end
  end

  assign pc_addr_o     = pc_r;
  assign stack_depth_o = stk_depth_s;
  assign pending_o     = pending_r;
  assign stack_ovf_o   = ovf_r;
  assign stack_unf_o   = unf_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized ops against a behavioural model.
module tb_pc_ctrl;
  import pc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  pc_op_e      op = OP_NOP;
  logic [15:0] data = 16'h0;
  logic [15:0] off = 16'h0;
  logic [23:0] pc_addr;
  logic [3:0]  depth;
  logic        pending, ovf, unf;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state.
  logic [23:0] m_pc;
  logic [15:0] m_stage;
  logic        m_held;
  logic        m_ovf, m_unf;
  logic [23:0] m_stk[$];

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .op_i          (op),
    .databus_i     (data),
    .offset_i      (off),
    .pc_addr_o     (pc_addr),
    .stack_depth_o (depth),
    .pending_o     (pending),
    .stack_ovf_o   (ovf),
    .stack_unf_o   (unf)
  );

  function automatic void model_reset();
    m_pc = 24'h0; m_stage = 16'h0; m_held = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_stk.delete();
  endfunction

  function automatic void model_step(input logic [2:0] o, input logic [15:0] d,
                                     input logic [15:0] f, input logic s);
    int t;
    logic [23:0] ret;
    if (s) return;
    case (o)
      3'd1: m_pc = m_pc + 24'd2;
      3'd2: begin
        t = int'(m_pc) + 2 + 2 * int'($signed(f));
        m_pc = t[23:0];
      end
      3'd3: begin
        m_stage = d & 16'hFFFE;
        m_held = 1'b1;
        return;
      end
      3'd4: if (m_held) m_pc = {d[7:0], m_stage};
      3'd5: if (m_held) begin
        ret = m_pc + 24'd2;
        if (m_stk.size() < 8) m_stk.push_back(ret);
        else m_ovf = 1'b1;
        m_pc = {d[7:0], m_stage};
      end
      3'd6: begin
        if (m_stk.size() == 0) begin
          m_pc = 24'h0;
          m_unf = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
      default: ;
    endcase
    m_held = 1'b0;
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [15:0] d,
                       input logic [15:0] f, input logic s);
    @(negedge clk);
    op = pc_op_e'(o); data = d; off = f; stall = s;
    @(posedge clk);
    model_step(o, d, f, s);
    #1;
  endtask

  task automatic set_pc(input logic [23:0] a);
    logic [15:0] hi;
    hi = {8'h00, a[23:16]};
    do_op(3'd3, a[15:0], 16'h0, 1'b0);
    do_op(3'd4, hi, 16'h0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; op = OP_NOP; stall = 1'b0; data = 16'h0; off = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (pc_addr !== 24'h0) begin n_fail++; $display("FAIL reset_pc got %h want 000000", pc_addr); end
    n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got %0d want 0", depth); end
    n_cmp++; if ({pending, ovf, unf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {pending, ovf, unf}); end
    repeat (3) do_op(3'd1, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h000006) begin n_fail++; $display("FAIL inc3 got %h want 000006", pc_addr); end
    do_op(3'd3, 16'hABCD, 16'h0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (pc_addr !== 24'h0) begin n_fail++; $display("FAIL async_reset_pc got %h want 000000", pc_addr); end
    n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL async_reset_pending got %b want 0", pending); end
    apply_reset();
  endtask

  task automatic test_bra_wrap();
    set_pc(24'h000100);
    n_cmp++; if (pc_addr !== 24'h000100) begin n_fail++; $display("FAIL set_pc got %h want 000100", pc_addr); end
    do_op(3'd2, 16'h0, 16'hFFFE, 1'b0);
    n_cmp++; if (pc_addr !== 24'h0000FE) begin n_fail++; $display("FAIL bra_neg got %h want 0000fe", pc_addr); end
    do_op(3'd2, 16'h0, 16'h0010, 1'b0);
    n_cmp++; if (pc_addr !== 24'h000120) begin n_fail++; $display("FAIL bra_pos got %h want 000120", pc_addr); end
    set_pc(24'hFFFFFE);
    do_op(3'd1, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h000000) begin n_fail++; $display("FAIL inc_wrap got %h want 000000", pc_addr); end
  endtask

  task automatic test_goto();
    do_op(3'd3, 16'h1235, 16'h0, 1'b0);
    n_cmp++; if (pending !== 1'b1) begin n_fail++; $display("FAIL loadl_pending got %b want 1", pending); end
    n_cmp++; if (pc_addr !== 24'h000000) begin n_fail++; $display("FAIL loadl_hold got %h want 000000", pc_addr); end
    do_op(3'd4, 16'h0012, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h121234) begin n_fail++; $display("FAIL goto got %h want 121234", pc_addr); end
    n_cmp++; if (pending !== 1'b0) begin n_fail++; $display("FAIL goto_pending got %b want 0", pending); end
    do_op(3'd3, 16'h5000, 16'h0, 1'b0);
    do_op(3'd1, 16'h0, 16'h0, 1'b0);
    do_op(3'd4, 16'h0012, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h121236) begin n_fail++; $display("FAIL drop_staged got %h want 121236", pc_addr); end
    do_op(3'd3, 16'h5000, 16'h0, 1'b0);
    do_op(3'd0, 16'h0, 16'h0, 1'b0);
    do_op(3'd4, 16'h0034, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h121236) begin n_fail++; $display("FAIL nop_cancels got %h want 121236", pc_addr); end
  endtask

  task automatic test_call_ret();
    set_pc(24'h000200);
    do_op(3'd3, 16'h4000, 16'h0, 1'b0);
    do_op(3'd5, 16'h0000, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h004000) begin n_fail++; $display("FAIL call_pc got %h want 004000", pc_addr); end
    n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL call_depth got %0d want 1", depth); end
    do_op(3'd6, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h000202) begin n_fail++; $display("FAIL ret_pc got %h want 000202", pc_addr); end
    n_cmp++; if (depth !== 4'd0) begin n_fail++; $display("FAIL ret_depth got %0d want 0", depth); end
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] lo;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      lo = 16'h1000 + 16'(i * 16);
      do_op(3'd3, lo, 16'h0, 1'b0);
      do_op(3'd5, 16'h0001, 16'h0, 1'b0);
    end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", ovf); end
    n_cmp++; if (depth !== 4'd8) begin n_fail++; $display("FAIL ovf_depth got %0d want 8", depth); end
    for (int i = 0; i < 9; i++) begin
      do_op(3'd6, 16'h0, 16'h0, 1'b0);
      n_cmp++; if (pc_addr !== m_pc) begin n_fail++; $display("FAIL ret_chain%0d got %h want %h", i, pc_addr, m_pc); end
    end
    n_cmp++; if (pc_addr !== 24'h000000) begin n_fail++; $display("FAIL unf_pc got %h want 000000", pc_addr); end
    n_cmp++; if (unf !== 1'b1) begin n_fail++; $display("FAIL unf_flag got %b want 1", unf); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    do_op(3'd1, 16'h0, 16'h0, 1'b0);
    n_cmp++; if (unf !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got %b want 1", unf); end
  endtask

  task automatic test_stall();
    apply_reset();
    set_pc(24'h000400);
    do_op(3'd3, 16'h8000, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 1'b1);
      n_cmp++; if ({pc_addr, pending, depth} !== {24'h000400, 1'b1, 4'd0}) begin
        n_fail++; $display("FAIL stall_hold got pc=%h pend=%b depth=%0d want 000400/1/0", pc_addr, pending, depth);
      end
    end
    do_op(3'd5, 16'h0033, 16'h0, 1'b0);
    n_cmp++; if (pc_addr !== 24'h338000) begin n_fail++; $display("FAIL stall_callh got %h want 338000", pc_addr); end
    n_cmp++; if (depth !== 4'd1) begin n_fail++; $display("FAIL stall_callh_depth got %0d want 1", depth); end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [15:0] d, f;
    logic        s;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      o = 3'($urandom_range(0, 7));
      // Favour calls/returns so the stack sees both edges.
      if ($urandom_range(0, 3) == 0) o = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6;
      d = 16'($urandom);
      f = 16'($urandom);
      s = ($urandom_range(0, 7) == 0);
      do_op(o, d, f, s);
      n_cmp++;
      if ({pc_addr, depth, pending, ovf, unf} !== {m_pc, 4'(m_stk.size()), m_held, m_ovf, m_unf}) begin
        n_fail++;
        $display("FAIL random%0d op=%0d got pc=%h d=%0d p=%b o=%b u=%b want pc=%h d=%0d p=%b o=%b u=%b",
                 i, o, pc_addr, depth, pending, ovf, unf, m_pc, m_stk.size(), m_held, m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bra_wrap();
    test_goto();
    test_call_ret();
    test_overflow_underflow();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
